// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter with lock sharing one ALU between NREQ requesters
module alu_arbiter #(
  parameter int WIDTH   = 16,
  parameter int NREQ    = 4,
  parameter int LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_lock,
  input  logic [4*NREQ-1:0]      req_cmd,
  input  logic [WIDTH*NREQ-1:0]  req_a,
  input  logic [WIDTH*NREQ-1:0]  req_b,
  output logic [3:0]             alu_cmd,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic                   alu_en,
  input  logic [WIDTH-1:0]       alu_result,
  input  logic                   alu_ready,
  output logic [NREQ-1:0]        resp_valid,
  output logic [WIDTH-1:0]       resp_data,
  output logic                   err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t           r_state;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    r_owner;
  logic [3:0]       r_alu_cmd;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic             r_alu_en;
  logic [PW-1:0]    r_issue_idx;
  logic             r_tag_v   [1:LATENCY];
  logic [PW-1:0]    r_tag_idx [1:LATENCY];
  logic [NREQ-1:0]  r_resp_valid;
  logic [WIDTH-1:0] r_resp_data;
  logic             r_err;

  logic             w_xfer;
  logic [PW-1:0]    w_gnt_idx;
  logic [PW-1:0]    w_cand;

  // Scan offsets from high to low so the candidate nearest ptr is written last and wins.
  always_comb begin
    w_xfer    = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    if (!reset) begin
      if (r_state == S_LOCKED) begin
        w_xfer    = req_valid[r_owner];
        w_gnt_idx = r_owner;
      end else begin
        for (int k = NREQ - 1; k >= 0; k--) begin
          w_cand = PW'((int'(r_ptr) + k) % NREQ);
          if (req_valid[w_cand]) begin
            w_xfer    = 1'b1;
            w_gnt_idx = w_cand;
          end
        end
      end
    end
  end

  assign req_ready = w_xfer ? (NREQ'(1) << w_gnt_idx) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_owner      <= '0;
      r_alu_cmd    <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_en     <= 1'b0;
      r_issue_idx  <= '0;
      r_resp_valid <= '0;
      r_resp_data  <= '0;
      r_err        <= 1'b0;
      for (int s = 1; s <= LATENCY; s++) begin
        r_tag_v[s]   <= 1'b0;
        r_tag_idx[s] <= '0;
      end
    end else begin
      r_alu_en    <= w_xfer;
      r_issue_idx <= w_gnt_idx;
      if (w_xfer) begin
        r_alu_cmd <= req_cmd[int'(w_gnt_idx)*4 +: 4];
        r_alu_a   <= req_a[int'(w_gnt_idx)*WIDTH +: WIDTH];
        r_alu_b   <= req_b[int'(w_gnt_idx)*WIDTH +: WIDTH];
        // While locked only the owner transfers, so ptr stays at owner+1.
        r_ptr     <= (w_gnt_idx == PW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
        case (r_state)
          S_IDLE: begin
            if (req_lock[w_gnt_idx]) begin
              r_state <= S_LOCKED;
              r_owner <= w_gnt_idx;
            end
          end
          S_LOCKED: begin
            if (!req_lock[w_gnt_idx]) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end

      r_tag_v[1]   <= r_alu_en;
      r_tag_idx[1] <= r_issue_idx;
      for (int s = 2; s <= LATENCY; s++) begin
        r_tag_v[s]   <= r_tag_v[s-1];
        r_tag_idx[s] <= r_tag_idx[s-1];
      end

      r_resp_valid <= '0;
      if (alu_ready && r_tag_v[LATENCY]) begin
        r_resp_valid <= NREQ'(1) << r_tag_idx[LATENCY];
        r_resp_data  <= alu_result;
      end else if (alu_ready || r_tag_v[LATENCY]) begin
        r_err <= 1'b1;
      end
    end
  end

  assign alu_cmd    = r_alu_cmd;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_en     = r_alu_en;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign err        = r_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed scoreboard bench for alu_arbiter with a behavioural 2-cycle ALU
module tb_alu_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [3:0]   req_lock;
  logic [15:0]  req_cmd;
  logic [63:0]  req_a;
  logic [63:0]  req_b;
  logic [3:0]   alu_cmd;
  logic [15:0]  alu_a;
  logic [15:0]  alu_b;
  logic         alu_en;
  logic [15:0]  alu_result;
  logic         alu_ready;
  logic [3:0]   resp_valid;
  logic [15:0]  resp_data;
  logic         err;

  logic [3:0]   t_cmd [4];
  logic [15:0]  t_a   [4];
  logic [15:0]  t_b   [4];
  logic         inj;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [15:0] model_acc;

  typedef struct {
    int          idx;
    logic [15:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  alu_arbiter #(.WIDTH(16), .NREQ(4), .LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock),
    .req_cmd(req_cmd), .req_a(req_a), .req_b(req_b),
    .alu_cmd(alu_cmd), .alu_a(alu_a), .alu_b(alu_b), .alu_en(alu_en),
    .alu_result(alu_result), .alu_ready(alu_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    req_cmd = '0;
    req_a   = '0;
    req_b   = '0;
    for (int i = 0; i < 4; i++) begin
      req_cmd[4*i +: 4]   = t_cmd[i];
      req_a[16*i +: 16]   = t_a[i];
      req_b[16*i +: 16]   = t_b[i];
    end
  end

  // Reference ALU: cmd[3] replaces b with the shared accumulator and writes the result back.
  function automatic logic [15:0] alu_f(logic [3:0] c, logic [15:0] a, logic [15:0] b, logic [15:0] acc);
    logic [15:0] y;
    y = c[3] ? acc : b;
    case (c[2:0])
      3'd1:    return a - y;
      3'd2:    return a & y;
      3'd3:    return a ^ y;
      default: return a + y;
    endcase
  endfunction

  logic        s1_v, s2_v;
  logic [15:0] s1_r, s2_r, alu_acc;
  always @(posedge clk) begin
    if (reset) begin
      s1_v <= 1'b0; s2_v <= 1'b0; s1_r <= '0; s2_r <= '0; alu_acc <= '0;
    end else begin
      s1_v <= alu_en;
      s2_v <= s1_v;
      s2_r <= s1_r;
      if (alu_en) begin
        s1_r <= alu_f(alu_cmd, alu_a, alu_b, alu_acc);
        if (alu_cmd[3]) alu_acc <= alu_f(alu_cmd, alu_a, alu_b, alu_acc);
      end
    end
  end
  assign alu_ready  = s2_v | inj;
  assign alu_result = s2_r;

  task automatic chk(logic [31:0] obs, logic [31:0] exp, string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, logic [3:0] c, logic [15:0] a, logic [15:0] b, logic lk);
    t_cmd[i]     = c;
    t_a[i]       = a;
    t_b[i]       = b;
    req_lock[i]  = lk;
    req_valid[i] = 1'b1;
  endtask

  task automatic grant(int i, string tag);
    exp_t e;
    #1;
    chk(32'(req_ready), 32'(4'b0001 << i), tag);
    e.idx  = i;
    e.data = alu_f(t_cmd[i], t_a[i], t_b[i], model_acc);
    e.cyc  = cyc + 4;
    if (t_cmd[i][3]) model_acc = e.data;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && sb.size() != 0; n++) tick();
    chk(32'(sb.size()), 32'd0, "drain");
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && resp_valid !== 4'b0000) begin
      if (sb.size() == 0) begin
        chk(32'(resp_valid), 32'd0, "unexpected_resp");
      end else begin
        e = sb.pop_front();
        chk(32'(resp_valid), 32'(4'b0001 << e.idx), "resp_onehot");
        chk(32'(resp_data), 32'(e.data), "resp_data");
        chk(32'(cyc), 32'(e.cyc), "resp_cycle");
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; inj = 1'b0; model_acc = '0;
    req_valid = 4'hF; req_lock = '0;
    for (int i = 0; i < 4; i++) begin t_cmd[i] = '0; t_a[i] = '0; t_b[i] = '0; end
    repeat (3) tick();
    chk(32'(req_ready), 32'd0, "reset_ready");
    chk(32'(alu_en), 32'd0, "reset_alu_en");
    chk(32'({alu_cmd, alu_a, alu_b}), 32'd0, "reset_alu_bus");
    chk(32'(resp_valid), 32'd0, "reset_resp_valid");
    chk(32'(resp_data), 32'd0, "reset_resp_data");
    chk(32'(err), 32'd0, "reset_err");
    req_valid = '0;
    reset = 1'b0;
    tick();

    set_req(2, 4'd0, 16'd5, 16'd7, 1'b0);
    grant(2, "single_grant");
    tick();
    req_valid = '0;
    chk(32'(alu_en), 32'd1, "single_alu_en");
    chk(32'({alu_cmd, alu_a}), 32'({4'd0, 16'd5}), "single_alu_a");
    chk(32'(alu_b), 32'd7, "single_alu_b");
    tick();
    chk(32'(alu_en), 32'd0, "single_alu_en_drop");
    repeat (2) tick();
    chk(32'(resp_valid), 32'b0100, "single_resp_valid");
    chk(32'(resp_data), 32'd12, "single_resp_data");
    tick();

    reset = 1'b1;
    model_acc = '0;
    for (int i = 0; i < 4; i++) set_req(i, 4'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 1'b0);
    #1 chk(32'(req_ready), 32'd0, "ready_forced_in_reset");
    tick();
    reset = 1'b0;
    for (int k = 0; k < 9; k++) begin
      grant(k % 4, "fair_grant");
      tick();
      set_req(k % 4, 4'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 1'b0);
    end

    set_req(1, 4'd8, 16'd3, 16'd0, 1'b1);
    grant(1, "lock_grant1");
    tick();
    req_valid[1] = 1'b0;
    #1 chk(32'(req_ready), 32'd0, "locked_owner_idle");
    tick();
    set_req(1, 4'd8, 16'd4, 16'd0, 1'b0);
    grant(1, "lock_grant2");
    chk(32'(sb[sb.size()-1].data), 32'd7, "lock_acc_model");
    tick();
    req_valid[1] = 1'b0;
    grant(2, "after_lock_ptr2");
    tick();
    req_valid[2] = 1'b0;
    grant(3, "after_lock_3");
    tick();
    req_valid[3] = 1'b0;
    grant(0, "after_lock_0");
    tick();
    req_valid = '0;
    drain();

    set_req(0, 4'd1, 16'd100, 16'd30, 1'b0);
    grant(0, "gap_grant0");
    tick();
    req_valid = '0;
    tick();
    set_req(3, 4'd2, 16'hF0F0, 16'h0FF0, 1'b0);
    grant(3, "gap_grant3");
    tick();
    req_valid = '0;
    drain();

    set_req(2, 4'd3, 16'h1234, 16'h00FF, 1'b0);
    grant(2, "midflight_grant");
    tick();
    req_valid = '0;
    tick();
    reset = 1'b1;
    sb.delete();
    model_acc = '0;
    tick();
    chk(32'({alu_en, resp_valid}), 32'd0, "midflight_reset_outputs");
    for (int i = 0; i < 4; i++) set_req(i, 4'd0, 16'(i), 16'd1, 1'b0);
    reset = 1'b0;
    grant(0, "post_reset_first");
    tick();
    req_valid = '0;
    repeat (8) tick();
    drain();

    chk(32'(err), 32'd0, "err_before_inject");
    inj = 1'b1;
    tick();
    inj = 1'b0;
    chk(32'(err), 32'd1, "err_rise");
    chk(32'(resp_valid), 32'd0, "err_no_resp");
    repeat (3) tick();
    chk(32'(err), 32'd1, "err_sticky");
    chk(32'(resp_valid), 32'd0, "err_no_resp_later");
    chk(32'(sb.size()), 32'd0, "final_queue_empty");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one `alu` instance (fixed 2-cycle `en`→`ready` latency, shared accumulator selected by `cmd[3]`) between `NREQ` requesters. Arbitration is round-robin with a per-requester lock that keeps accumulate sequences atomic. Each ALU issue is tagged with its requester index, and the result is routed back to that requester as a one-hot response pulse. The block sits between the requester ports and the ALU's `cmd/a/b/en` inputs and `result/ready` outputs.

## Interface
- `WIDTH`, 16, operand/result width; must match the ALU's `WIDTH`.
- `NREQ`, 4, number of requesters, 2..8.
- `LATENCY`, 2, ALU cycles from `en` to `ready`; sets the tag pipeline depth.
- reset and clock (already decided): reset `reset`, synchronous, active-high; clock `clk`.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous active-high reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester grant; at most one bit high.
- `req_lock`  in  NREQ  hold the grant after this request.
- `req_cmd`  in  4*NREQ  requester i uses bits [4i+3:4i].
- `req_a`, `req_b`  in  WIDTH*NREQ  requester i uses bits [WIDTH*i+WIDTH-1:WIDTH*i].
- `alu_cmd`  out  4  registered command to the ALU.
- `alu_a`, `alu_b`  out  WIDTH  registered operands to the ALU.
- `alu_en`  out  1  registered issue strobe.
- `alu_result`  in  WIDTH  ALU result.
- `alu_ready`  in  1  ALU result valid.
- `resp_valid`  out  NREQ  one-hot 1-cycle response pulse.
- `resp_data`  out  WIDTH  response data, valid while any `resp_valid` bit is high.
- `err`  out  1  sticky protocol error flag.

## Operation
- Handshake:
  - A transfer occurs when `req_valid[i] & req_ready[i]`.
  - The requester holds `valid` and its payload stable until the transfer.
  - At most one transfer per cycle; full throughput is one per cycle.
- `req_ready` is combinational from `req_valid`, pointer and lock state. It is forced to 0 while `reset` is high.
- Round-robin:
  - Search starts at `ptr`. The lowest index ≥ `ptr` with `valid` wins; the search wraps to 0.
  - After a transfer from requester i, `ptr` becomes (i+1) mod NREQ.
- Lock FSM, states IDLE and LOCKED(owner):
  - IDLE→LOCKED(i): on a transfer from i with `req_lock[i]=1`.
  - LOCKED(i): only requester i can be granted; `ptr` is frozen.
  - LOCKED(i)→IDLE: on a transfer from i with `req_lock[i]=0`. `ptr` then becomes i+1.
- Issue: on a transfer, the next cycle drives `alu_en=1` with the captured `cmd/a/b`. Otherwise `alu_en=0` and `cmd/a/b` hold their last values.
- Tag pipeline:
  - Shift register `LATENCY` deep of {valid, index}, loaded in step with `alu_en`.
  - When `alu_ready` is high, the stage-`LATENCY` entry must be valid. The next cycle then drives `resp_valid[index]=1` and `resp_data=alu_result`.
  - `alu_ready` high with the stage entry invalid, or stage entry valid with `alu_ready` low: set `err` (sticky until reset) and drop the response.
- There is no response backpressure; requesters must sink `resp_valid` in the cycle it appears.
- Accumulator coherence (`cmd[3]=1`) is guaranteed only inside a locked sequence. The arbiter does not inspect `cmd`.

## Timing
- Reset values:
  - Outputs: `req_ready=0`, `alu_en=0`, `alu_cmd/a/b=0`, `resp_valid=0`, `resp_data=0`, `err=0`.
  - Internal: `ptr=0`, FSM IDLE, tag pipeline all invalid.
- Latency, with transfer in cycle 0:
  - Cycle 1: `alu_en` high.
  - Cycle 3: `alu_ready` high.
  - Cycle 4: `resp_valid` high.
  - Request-to-response latency is 4 cycles.
- Back-to-back transfers produce back-to-back responses in issue order.
- A transfer from an idle requester takes effect in the same cycle its `req_valid` rises, provided it wins arbitration.
- Reset mid-operation:
  - All in-flight tags are discarded and the lock is released.
  - No response is emitted for work issued before reset.
  - The ALU shares the reset, so no stray `alu_ready` follows.
- In LOCKED with the owner's `req_valid` low: `req_ready` is all-zero and other requesters wait indefinitely.

## Test plan
- Single op: requester 2 sends cmd=0, a=5, b=7 in cycle 0 → `alu_en` in cycle 1; `resp_valid=4'b0100`, `resp_data=12` in cycle 4.
- Fairness: all four requesters hold `valid` continuously from reset → grants 0,1,2,3,0,1… one per cycle; responses arrive 4 cycles after each grant with matching one-hot.
- Lock sequence:
  - Stimulus: requester 1 sends cmd=8 (a=3, b=0, lock=1), then cmd=8 (a=4, b=0, lock=0), while requesters 0/2/3 are also valid.
  - Required: requester 1 is granted twice consecutively and the others are blocked; then `ptr`=2 and requester 2 is granted next.
- Response routing under a gap: requester 0 transfers in cycle 0 and requester 3 in cycle 2 → responses on bit 0 in cycle 4 and bit 3 in cycle 6.
- Error: inject `alu_ready=1` with no issue outstanding → `err` rises the next cycle and stays high; `resp_valid` remains 0.
- Reset mid-flight: transfer in cycle 0, reset high in cycle 2 → no `resp_valid` ever appears for that op; after reset release, requester 0 wins first.
